// File: rtl/lcd_host_seq.sv
// Host side of the LCD controller link: image ROM source, command issuer, IRAM capture.
// Optional protocol checker enabled by defining LCD_HOST_CHK_EN.
module lcd_host_seq #(
  parameter int CQ_DEPTH = 16,
  parameter int CQ_AW    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_we,
  input  logic [5:0] ld_addr,
  input  logic [7:0] ld_data,
  input  logic       cq_push,
  input  logic [3:0] cq_data,
  output logic       cq_full,
  input  logic       start,
  input  logic       IROM_rd,
  input  logic [5:0] IROM_A,
  output logic [7:0] IROM_Q,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  input  logic       busy,
  input  logic       done,
  input  logic       IRAM_valid,
  input  logic [5:0] IRAM_A,
  input  logic [7:0] IRAM_D,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       run_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GAP,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state, state_nx;

  logic [7:0] rom [64];
  logic [7:0] cap [64];
  logic [3:0] fifo [CQ_DEPTH];

  logic [CQ_AW-1:0] wp, rp;
  logic [CQ_AW:0]   count;
  logic             busy_d;

  logic       empty;
  logic       push_ok;
  logic       push_drop;
  logic       pop;
  logic       go;
  logic       chk_err;
  logic       err_set;
  logic [3:0] head;

  assign empty     = (count == '0);
  assign cq_full   = (32'(count) == CQ_DEPTH);
  assign push_ok   = cq_push && !cq_full;
  assign push_drop = cq_push && cq_full;
  assign head      = fifo[rp];
  assign go        = (state == S_IDLE) && start;
  assign err_set   = push_drop || chk_err;

  assign IROM_Q  = IROM_rd ? rom[IROM_A] : 8'd0;
  assign rd_data = cap[rd_addr];

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (busy_d && !busy) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (!empty && !busy) begin
          pop      = 1'b1;
          state_nx = (head == 4'd0) ? S_DRAIN : S_GAP;
        end
      end
      S_GAP:   state_nx = S_ISSUE;
      S_DRAIN: if (done) state_nx = S_FIN;
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy_d    <= 1'b0;
      cmd       <= 4'd0;
      cmd_valid <= 1'b0;
      run_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      busy_d    <= busy;
      cmd_valid <= pop;
      if (pop) cmd <= head;
      if (go) run_done <= 1'b0;
      else if (state == S_DRAIN && done) run_done <= 1'b1;
      if (go) err <= err_set;
      else if (err_set) err <= 1'b1;
    end
  end

  // Queue bookkeeping; a full queue drops pushes even if it pops this cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wp] <= cq_data;
    if (ld_we && state == S_IDLE) rom[ld_addr] <= ld_data;
    if (IRAM_valid) cap[IRAM_A] <= IRAM_D;
  end

`ifdef LCD_HOST_CHK_EN
  logic [6:0] wcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 7'd0;
    else if (go) wcnt <= 7'd0;
    else if (IRAM_valid) wcnt <= wcnt + 7'd1;
  end

  assign chk_err = (IRAM_valid && IRAM_A != wcnt[5:0])
                || (done && wcnt != 7'd64)
                || (busy && cmd_valid);
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/lcd_host_seq.md
Name: lcd_host_seq

Overview:
- Host-side counterpart of the LCD image controller: acts as IROM image source, command issuer and IRAM write sink.
- Software or the bench preloads a 64x8 image and queues 4-bit commands. The block feeds the controller's IROM reads, issues queued commands under the busy handshake, and captures the controller's IRAM writes.
- Captured image is readable through a side port. Sits opposite the controller in system and bench.

Parameters:
- CQ_DEPTH, 16, command FIFO depth (power of two, >=2)
- CQ_AW, 4, log2(CQ_DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ld_we  input  1  image preload write strobe (honoured only in IDLE)
- ld_addr  input  6  preload address
- ld_data  input  8  preload pixel
- cq_push  input  1  push command into FIFO
- cq_data  input  4  command code (0 = Write/flush, 1..11 = operations)
- cq_full  output  1  FIFO full
- start  input  1  one-cycle pulse, begin run
- IROM_rd  input  1  controller ROM read enable
- IROM_A  input  6  controller ROM address
- IROM_Q  output  8  ROM data to controller
- cmd  output  4  command to controller
- cmd_valid  output  1  command strobe to controller
- busy  input  1  controller busy
- done  input  1  controller finished output phase
- IRAM_valid  input  1  controller write strobe
- IRAM_A  input  6  controller write address
- IRAM_D  input  8  controller write data
- rd_addr  input  6  captured-image read address
- rd_data  output  8  captured pixel, combinational from capture RAM
- run_done  output  1  high from end of run until next start
- err  output  1  sticky protocol error, cleared by start

Behaviour:
- Reset values:
  - Outputs: cmd=0, cmd_valid=0, run_done=0, err=0, cq_full=0.
  - State and FIFO: state=IDLE, FIFO pointers and count=0.
  - Image and capture RAMs are not reset.
- IROM_Q = rom[IROM_A] when IROM_rd=1, else 0. Combinational, zero latency, because the controller samples IROM_Q in the same cycle it presents IROM_A.
- Preload: ld_we in IDLE writes rom[ld_addr]<=ld_data. Ignored in any other state.
- FIFO:
  - cq_push when not full stores cq_data. Push when full is dropped and sets err.
  - Push and pop in the same cycle keeps count unchanged.
  - cq_full=(count==CQ_DEPTH).
- State machine:
  - IDLE: start -> LOAD.
  - LOAD: controller reads ROM. Wait for busy 1->0 (registered busy_d=1 and busy=0) -> ISSUE.
  - ISSUE: if FIFO empty, wait. Otherwise, with busy=0, pop head, drive cmd=head, cmd_valid=1 for exactly one cycle -> GAP if head!=0, DRAIN if head==0.
  - GAP: cmd_valid=0, one cycle spacing -> ISSUE.
  - DRAIN: capture IRAM writes. On done=1 -> FIN.
  - FIN: run_done=1 and remains 1 in IDLE -> IDLE.
- cmd holds its last value when cmd_valid=0.
- Throughput: at most one command per 2 cycles.
- Capture: IRAM_valid=1 in any state writes cap[IRAM_A]<=IRAM_D on that edge.
- Commands left in the FIFO after a Write stay queued for the next run.
- start outside IDLE is ignored.
- Asserting reset mid-run aborts immediately to IDLE. FIFO is emptied; ROM and capture contents are retained.

Optional Feature:
- Macro LCD_HOST_CHK_EN.
- Defined:
  - 7-bit write counter, cleared at start.
  - err is set if IRAM_valid arrives with IRAM_A != counter[5:0].
  - err is set if done arrives with counter != 64.
  - err is set if busy=1 while cmd_valid=1.
- Undefined: err reflects only FIFO overflow. Counter logic is absent.

Test Plan:
- Preload rom[i]=i, queue {0}, start; controller model reads 0..63 -> IROM_Q tracks address; cap[i]=i; run_done=1; err=0.
- Queue {1,3,5,0}; controller drops busy -> cmd_valid pulses carry 1,3,5,0 on cycles N, N+2, N+4, N+6, each pulse one cycle wide.
- Empty FIFO after load -> no cmd_valid for 20 cycles; push 0 -> pulse within 2 cycles.
- Push 17 commands with CQ_DEPTH=16 -> cq_full=1 after 16th; 17th dropped; err=1; next start clears err.
- Assert reset during DRAIN -> state IDLE, cmd_valid=0, cq_full=0 on the next edge; rom contents intact via IROM_Q.
- With LCD_HOST_CHK_EN: controller model writes address 5 before 4 -> err=1; done after 63 writes -> err=1.
